// File: rtl/wb_debug_bus_arbiter.sv
// Round-robin arbiter sharing one downstream bus-master port between the Caravel
// Wishbone slave and the UART debug bridge, with a per-transfer timeout abort.
module wb_debug_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hBAD0_BAD0)
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [DATA_W/8-1:0] wbs_sel_i,
  input  logic [ADDR_W-1:0]   wbs_adr_i,
  input  logic [DATA_W-1:0]   wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [DATA_W-1:0]   wbs_dat_o,
  input  logic                dbg_req_i,
  input  logic                dbg_we_i,
  input  logic [DATA_W/8-1:0] dbg_strb_i,
  input  logic [ADDR_W-1:0]   dbg_addr_i,
  input  logic [DATA_W-1:0]   dbg_wdata_i,
  output logic                dbg_done_o,
  output logic                dbg_err_o,
  output logic [DATA_W-1:0]   dbg_rdata_o,
  output logic                m_req_o,
  output logic                m_we_o,
  output logic [DATA_W/8-1:0] m_strb_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  input  logic                m_ready_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  output logic                owner_o,
  output logic                timeout_o
);
  localparam int SW    = DATA_W / 8;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [SW-1:0]      strb_q, strb_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic wb_rq, dbg_rq, pick_dbg, expire;

  assign wb_rq    = wbs_cyc_i & wbs_stb_i;
  assign dbg_rq   = dbg_req_i;
  // Debug wins when alone, or on a tie when Wishbone was the last owner.
  assign pick_dbg = dbg_rq & (~wb_rq | ~last_q);
  assign expire   = (cnt_q == CNT_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wb_rq | dbg_rq) state_d = BUSY;
      BUSY:    if (m_ready_i | expire) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    strb_d  = strb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && (wb_rq | dbg_rq)) begin
      we_d    = pick_dbg ? dbg_we_i    : wbs_we_i;
      strb_d  = pick_dbg ? dbg_strb_i  : wbs_sel_i;
      addr_d  = pick_dbg ? dbg_addr_i  : wbs_adr_i;
      wdata_d = pick_dbg ? dbg_wdata_i : wbs_dat_i;
      owner_d = pick_dbg;
      last_d  = pick_dbg;
      cnt_d   = '0;
      err_d   = 1'b0;
      drop_d  = 1'b0;
    end else if (state_q == BUSY) begin
      // A Wishbone master that abandons the cycle still lets the transfer finish silently.
      if (!owner_q && !wbs_cyc_i) drop_d = 1'b1;
      if (m_ready_i) begin
        rdata_d = m_rdata_i;
        err_d   = 1'b0;
      end else if (expire) begin
        rdata_d = ERR_DATA;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_q    <= 1'b0;
      strb_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      strb_q  <= strb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    m_req_o     = (state_q == BUSY);
    wbs_ack_o   = (state_q == RESP) & ~owner_q & wbs_cyc_i & ~drop_q;
    dbg_done_o  = (state_q == RESP) & owner_q & dbg_req_i;
    wbs_dat_o   = wbs_ack_o  ? rdata_q : '0;
    dbg_rdata_o = dbg_done_o ? rdata_q : '0;
    dbg_err_o   = dbg_done_o & err_q;
    timeout_o   = (state_q == RESP) & err_q;
  end

  assign m_we_o    = we_q;
  assign m_strb_o  = strb_q;
  assign m_addr_o  = addr_q;
  assign m_wdata_o = wdata_q;
  assign owner_o   = owner_q;

endmodule
